// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a small TX FIFO and runtime frame format.
// Frames are start(0), 5..8 data bits LSB first, optional even/odd parity and
// 1 or 2 stop bits. Each bit lasts div+1 clocks. The frame format is captured
// when a frame starts, so config writes never disturb a frame already on the line.
//
// Ports:
//   clk, reset      clock; asynchronous active-low reset
//   div             baud divisor (bit period = div+1 clocks)
//   data_len        data bits: 0->5, 1->6, 2->7, 3->8
//   parity_en       append a parity bit
//   parity_odd      1 = odd parity, 0 = even parity
//   stop2           1 = two stop bits
//   wr_en, wr_data  push a byte into the FIFO
//   fifo_full/empty/count  FIFO occupancy status
//   overflow        one-cycle pulse when a push hits a full FIFO (byte dropped)
//   tx_busy         high in any state but IDLE
//   tx_end          one-cycle pulse after the last stop-bit cycle
//   tx              registered serial output, idle high
module uart_tx_fifo #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       data_len,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  output logic             tx_busy,
  output logic             tx_end,
  output logic             tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Frame format captured at frame start.
  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [1:0]       len;
    logic             par_en;
    logic             stop2;
  } cfg_t;

  // ---------------- FIFO ----------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;

  // Fullness is judged before the edge, so a same-cycle pop never frees room.
  assign push       = wr_en && !fifo_full;
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= wr_en && fifo_full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  // ---------------- transmitter ----------------
  state_t           state, state_d;
  cfg_t             cfg, cfg_d;
  logic [7:0]       shreg, shreg_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [DIV_W-1:0] cnt, cnt_d;
  logic             par_bit, par_bit_d;
  logic             stop_2nd, stop_2nd_d;
  logic             tx_d, tx_end_d;
  logic             start;
  logic [7:0]       head, mask;
  logic [2:0]       last_idx;

  assign head     = mem[rd_ptr];
  assign last_idx = {1'b0, cfg.len} + 3'd4;   // N-1 for N = len+5
  assign tx_busy  = (state != IDLE);

  always_comb begin
    case (data_len)
      2'd0:    mask = 8'h1F;
      2'd1:    mask = 8'h3F;
      2'd2:    mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
  end

  always_comb begin
    state_d    = state;
    cfg_d      = cfg;
    shreg_d    = shreg;
    bit_idx_d  = bit_idx;
    cnt_d      = cnt;
    par_bit_d  = par_bit;
    stop_2nd_d = stop_2nd;
    tx_d       = tx;
    tx_end_d   = 1'b0;
    start      = 1'b0;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty) start = 1'b1;
      end
      default: begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          cnt_d = cfg.div;
          case (state)
            START: begin
              tx_d      = shreg[0];
              shreg_d   = shreg >> 1;
              bit_idx_d = 3'd0;
              state_d   = DATA;
            end
            DATA: begin
              if (bit_idx == last_idx) begin
                if (cfg.par_en) begin
                  tx_d    = par_bit;
                  state_d = PARITY;
                end else begin
                  tx_d       = 1'b1;
                  stop_2nd_d = 1'b0;
                  state_d    = STOP;
                end
              end else begin
                tx_d      = shreg[0];
                shreg_d   = shreg >> 1;
                bit_idx_d = bit_idx + 3'd1;
              end
            end
            PARITY: begin
              tx_d       = 1'b1;
              stop_2nd_d = 1'b0;
              state_d    = STOP;
            end
            STOP: begin
              if (cfg.stop2 && !stop_2nd) begin
                stop_2nd_d = 1'b1;
              end else begin
                tx_end_d = 1'b1;
                tx_d     = 1'b1;
                state_d  = IDLE;
                // Chain straight into the next frame when data is waiting.
                if (!fifo_empty) start = 1'b1;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end
    endcase

    // Frame start: pop head, capture format, precompute parity, drive start bit.
    if (start) begin
      pop          = 1'b1;
      shreg_d      = head;
      cfg_d.div    = div;
      cfg_d.len    = data_len;
      cfg_d.par_en = parity_en;
      cfg_d.stop2  = stop2;
      par_bit_d    = (^(head & mask)) ^ parity_odd;
      cnt_d        = div;
      tx_d         = 1'b0;
      state_d      = START;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cfg      <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      cnt      <= '0;
      par_bit  <= 1'b0;
      stop_2nd <= 1'b0;
      tx       <= 1'b1;
      tx_end   <= 1'b0;
    end else begin
      state    <= state_d;
      cfg      <= cfg_d;
      shreg    <= shreg_d;
      bit_idx  <= bit_idx_d;
      cnt      <= cnt_d;
      par_bit  <= par_bit_d;
      stop_2nd <= stop_2nd_d;
      tx       <= tx_d;
      tx_end   <= tx_end_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo. Accepted pushes queue a frame record
// (byte + format in force); a monitor rebuilds the expected line waveform from
// the UART framing rules and compares it cycle by cycle, plus tx_end/tx_busy.
module tb_uart_tx_fifo;
  localparam int DIV_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [1:0]       data_len = 2'd3;
  logic             parity_en = 1'b0, parity_odd = 1'b0, stop2 = 1'b0;
  logic             wr_en = 1'b0;
  logic [7:0]       wr_data = '0;
  logic             fifo_full, fifo_empty, overflow, tx_busy, tx_end, tx;
  logic [CNT_W-1:0] fifo_count;

  uart_tx_fifo #(.DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .div(div), .data_len(data_len),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .wr_en(wr_en), .wr_data(wr_data), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_count(fifo_count), .overflow(overflow),
    .tx_busy(tx_busy), .tx_end(tx_end), .tx(tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         div;
    int         nbits;
    bit         par_en;
    bit         par_odd;
    bit         stop2;
  } frame_t;

  frame_t sb[$];
  bit     exp_wave[$];
  frame_t cur;
  int     checks = 0, failures = 0;
  int     ovf_seen = 0, cnt_peak = 0, idle_err = 0, frames_seen = 0;
  bit     mon_en = 0, in_frame = 0, pend_end = 0, b2b = 0, spur = 0;
  int     idx, bad_idx;
  logic   bad_tx, bad_busy, bad_exp;

  // Per-cycle line levels of one frame, straight from the framing rules.
  function automatic void build_wave(input frame_t f);
    bit bits[$];
    int ones = 0;
    exp_wave.delete();
    bits.push_back(1'b0);
    for (int i = 0; i < f.nbits; i++) begin
      bits.push_back(f.data[i]);
      ones += int'(f.data[i]);
    end
    if (f.par_en) bits.push_back(f.par_odd ? ((ones % 2) == 0) : ((ones % 2) == 1));
    bits.push_back(1'b1);
    if (f.stop2) bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k <= f.div; k++) exp_wave.push_back(bits[i]);
  endfunction

  function automatic frame_t mk(input logic [7:0] b);
    frame_t f;
    f.data = b; f.div = int'(div); f.nbits = int'(data_len) + 5;
    f.par_en = parity_en; f.par_odd = parity_odd; f.stop2 = stop2;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int d, input int len, input bit pe, input bit po, input bit s2);
    div = DIV_W'(d); data_len = 2'(len); parity_en = pe; parity_odd = po; stop2 = s2;
  endtask

  task automatic push(input logic [7:0] b, input bit accept);
    wr_en = 1'b1; wr_data = b;
    if (accept) sb.push_back(mk(b));
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; n < 3000; n++) begin
      tick();
      if (sb.size() == 0 && !in_frame && !pend_end && tx_busy === 1'b0 && fifo_empty === 1'b1) break;
    end
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL %s_drain: frames left=%0d busy=%b, required all frames sent", name, sb.size(), tx_busy);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      bit idle_cyc;
      @(negedge clk);
      if (!mon_en) begin
        in_frame = 0; pend_end = 0; spur = 0;
        continue;
      end
      if (overflow === 1'b1) ovf_seen++;
      if (int'(fifo_count) > cnt_peak) cnt_peak = int'(fifo_count);
      idle_cyc = !in_frame && !pend_end;
      if (tx === 1'b1) spur = 0;
      if (pend_end) begin
        pend_end = 0;
        checks++;
        if (tx_end !== 1'b1 || tx_busy !== b2b) begin
          failures++;
          $display("FAIL frame_end: tx_end=%b tx_busy=%b, required tx_end=1 tx_busy=%b", tx_end, tx_busy, b2b);
        end
        if (b2b) begin
          checks++;
          if (tx !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back: tx=%b, required 0 (next start bit)", tx);
          end
        end
      end else if (idle_cyc && tx === 1'b1 && (tx_end !== 1'b0 || tx_busy !== 1'b0)) begin
        idle_err++;
      end
      if (!in_frame && tx === 1'b0 && !spur) begin
        frames_seen++;
        checks++;
        if (sb.size() == 0) begin
          failures++; spur = 1;
          $display("FAIL unexpected_frame: tx fell with nothing queued, required tx=1");
        end else begin
          cur = sb.pop_front();
          build_wave(cur);
          idx = 0; bad_idx = -1; in_frame = 1;
        end
      end
      if (in_frame) begin
        if (bad_idx < 0 && (tx !== exp_wave[idx] || tx_busy !== 1'b1)) begin
          bad_idx = idx; bad_tx = tx; bad_busy = tx_busy; bad_exp = exp_wave[idx];
        end
        idx++;
        if (idx == exp_wave.size()) begin
          checks++;
          if (bad_idx >= 0) begin
            failures++;
            $display("FAIL frame_%02h: cycle %0d tx=%b busy=%b, required tx=%b busy=1",
                     cur.data, bad_idx, bad_tx, bad_busy, bad_exp);
          end
          in_frame = 0; pend_end = 1; b2b = (sb.size() != 0);
        end
      end
    end
  end

  initial begin
    int n, fr0;
    // Reset state
    repeat (2) tick();
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_tx_end", tx_end, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_count", fifo_count, 0);
    reset = 1'b1;
    tick();
    mon_en = 1;

    // 8N1 single byte: 40-clock frame
    set_cfg(3, 3, 0, 0, 0);
    push(8'h55, 1);
    wait_idle("8n1");

    // 7E2: bit 7 ignored, 11-clock frame
    set_cfg(0, 2, 1, 0, 1);
    push(8'h83, 1);
    wait_idle("7e2");

    // 5-bit odd then even parity
    set_cfg(0, 0, 1, 1, 0);
    push(8'h1F, 1);
    wait_idle("5o1");
    parity_odd = 1'b0;
    push(8'h1F, 1);
    wait_idle("5e1");

    // Fill and overflow: one frame on the line so no pop happens during the burst,
    // then 5 consecutive pushes; the 5th meets a full FIFO.
    set_cfg(15, 3, 0, 0, 0);
    ovf_seen = 0; cnt_peak = 0;
    push(8'hA0, 1);
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      push(8'hB0 + 8'(i), i < 4);
      if (i == 3) begin
        chk("fill_full", fifo_full, 1);
        chk("fill_count", fifo_count, 4);
      end
    end
    tick();
    chk("fill_overflow_pulse", 32'(ovf_seen), 1);
    wait_idle("fill");
    chk("fill_overflow_once", 32'(ovf_seen), 1);
    chk("fill_peak", 32'(cnt_peak), 4);

    // Mid-frame divisor change affects only the next frame
    set_cfg(7, 3, 0, 0, 0);
    push(8'hA5, 1);
    repeat (20) tick();
    div = DIV_W'(1);
    push(8'h3C, 1);
    wait_idle("midcfg");

    // Reset during DATA with two bytes queued
    set_cfg(7, 3, 0, 0, 0);
    push(8'h11, 1); push(8'h22, 1); push(8'h33, 1);
    repeat (30) tick();
    #2;
    mon_en = 0;
    reset = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", tx_busy, 0);
    chk("midrst_empty", fifo_empty, 1);
    sb.delete();
    tick();
    reset = 1'b1;
    tick();
    mon_en = 1;
    fr0 = frames_seen;
    repeat (150) tick();
    chk("midrst_no_frame", 32'(frames_seen - fr0), 0);
    chk("midrst_tx_idle", tx, 1);

    // Randomized formats and bursts
    for (int it = 0; it < 20; it++) begin
      set_cfg($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n = $urandom_range(1, FIFO_DEPTH);
      for (int k = 0; k < n; k++) push(8'($urandom), 1);
      wait_idle("rand");
    end

    chk("idle_stray_outputs", 32'(idle_err), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
